fetch_unit: RTL and testbench

//  Instruction-fetch stage placed directly upstream of the Controller.
//  - Owns the PC and fetches one 32-bit instruction per handshake from instruction memory.
//  - Presents instr[31:26] (opcode) and instr[5:0] (funct) to the Controller.
//  - Takes back Branch/Jump/Jr from the Controller and Zero from the ALU to form the next PC.
//  - Memory latency is variable; execution accepts each instruction through a valid/ready pair.

---
 rtl/fetch_unit_if.sv | 34 +++
 rtl/fetch_unit.sv | 120 ++++++++++++
 tb/tb_fetch_unit.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction memory request/ack, instruction valid/ready to the datapath,
// and the redirect inputs from Controller/ALU. fetch_unit drives the master modport.
interface fetch_unit_if;
  // Handshakes:
  //  imem:  imem_req stays high with imem_addr stable until the cycle imem_ack=1, which
  //         carries imem_rdata; imem_ack is ignored whenever imem_req is low.
  //  instr: instr_valid=1 holds instr/pc stable; the transfer completes on the cycle
  //         instr_valid && instr_ready. Branch/Zero/Jump/Jr/rs_data are sampled only then.
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        Branch;
  logic        Zero;
  logic        Jump;
  logic        Jr;
  logic [31:0] rs_data;
  logic        fetch_err;

  modport master (
    output imem_req, imem_addr, instr, instr_valid, pc, pc_plus4, fetch_err,
    input  imem_ack, imem_rdata, instr_ready, Branch, Zero, Jump, Jr, rs_data
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid, pc, pc_plus4, fetch_err,
    output imem_ack, imem_rdata, instr_ready, Branch, Zero, Jump, Jr, rs_data
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches one word per imem handshake, forms next PC.
// Optional fetch timeout with sticky fetch_err is enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus,
  output logic [1:0]   state_o
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] pc_plus4_q;
  logic [31:0] instr_q;
  logic        valid_q;
  logic [31:0] next_pc_d;
  logic [31:0] br_off;
  logic        retire;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);
  logic [7:0] wait_cnt_q;
  logic       fetch_err_q;
  logic       timeout;
  assign timeout = (wait_cnt_q + 8'd1) == TIMEOUT_LIM;
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT_CYCLES);
`endif

  logic unused_rs_low;
  assign unused_rs_low = ^bus.rs_data[1:0];

  assign retire = (state_q == S_HOLD) && bus.instr_ready;

  // Redirect priority: Jr over Jump over taken branch; jalr therefore takes the Jr path.
  always_comb begin
    br_off    = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    next_pc_d = pc_plus4_q;
    if (bus.Jr) begin
      next_pc_d = {bus.rs_data[31:2], 2'b00};
    end else if (bus.Jump) begin
      next_pc_d = {pc_plus4_q[31:28], instr_q[25:0], 2'b00};
    end else if (bus.Branch && bus.Zero) begin
      next_pc_d = pc_plus4_q + br_off;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      pc_plus4_q <= RESET_PC + 32'd4;
      instr_q    <= '0;
      valid_q    <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt_q  <= '0;
      fetch_err_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_FETCH, S_WAIT: begin
          if (bus.imem_ack) begin
            instr_q <= bus.imem_rdata;
            valid_q <= 1'b1;
            state_q <= S_HOLD;
`ifdef FETCH_TIMEOUT_EN
          end else if (state_q == S_WAIT && timeout) begin
            // Give up on this fetch: hand a nop downstream and flag the error.
            instr_q     <= '0;
            valid_q     <= 1'b1;
            fetch_err_q <= 1'b1;
            state_q     <= S_HOLD;
`endif
          end else begin
            state_q <= S_WAIT;
          end
`ifdef FETCH_TIMEOUT_EN
          if (state_q == S_WAIT) wait_cnt_q <= wait_cnt_q + 8'd1;
`endif
        end
        S_HOLD: begin
          if (retire) begin
            pc_q       <= next_pc_d;
            pc_plus4_q <= next_pc_d + 32'd4;
            valid_q    <= 1'b0;
            state_q    <= S_FETCH;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt_q <= '0;
`endif
          end
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

  // Request is gated by rst_n so it drops the instant reset asserts.
  assign bus.imem_req    = rst_n && (state_q != S_HOLD);
  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_plus4_q;
`ifdef FETCH_TIMEOUT_EN
  assign bus.fetch_err   = fetch_err_q;
`else
  assign bus.fetch_err   = 1'b0;
`endif
  assign state_o         = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reference PC/instruction model plus per-cycle compare.
// Timeout scenario is exercised when FETCH_TIMEOUT_EN is defined.
module tb_fetch_unit;
  localparam int TO_CYCLES = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;
  int         n_checks = 0;
  int         n_errors = 0;
  bit         cmp_en = 1'b0;

  logic [31:0] mdl_pc;
  logic [31:0] mdl_instr;
  logic        mdl_err;

  localparam logic [31:0] ADDI = 32'h2008_0005;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(TO_CYCLES)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Next PC from the ISA rules, written as plain integer arithmetic.
  function automatic logic [31:0] spec_next(input logic [31:0] p, input logic [31:0] ins,
                                            input logic br, input logic z, input logic j,
                                            input logic jr, input logic [31:0] rs);
    logic [31:0] seq;
    int          off;
    seq = p + 32'd4;
    if (jr) return rs & 32'hFFFF_FFFC;
    if (j)  return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
    if (br && z) begin
      off = $signed(ins[15:0]);
      return seq + 32'(off * 4);
    end
    return seq;
  endfunction

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      check32("req_xor_valid", 32'(bus.imem_req), 32'(!bus.instr_valid));
      if (bus.instr_valid) begin
        check32("instr", bus.instr, mdl_instr);
        check32("pc", bus.pc, mdl_pc);
        check32("pc_plus4", bus.pc_plus4, mdl_pc + 32'd4);
      end
      if (bus.imem_req) check32("imem_addr", bus.imem_addr, mdl_pc);
      check32("fetch_err", 32'(bus.fetch_err), 32'(mdl_err));
    end
  end

  task automatic clear_redirect();
    bus.instr_ready = 1'b0;
    bus.Branch      = 1'b0;
    bus.Zero        = 1'b0;
    bus.Jump        = 1'b0;
    bus.Jr          = 1'b0;
    bus.rs_data     = 32'h0;
  endtask

  // One fetch: ack after lat wait cycles, hold hold cycles, then retire with redirects.
  task automatic do_fetch(input logic [31:0] addr_lit, input logic [31:0] rdata,
                          input int lat, input int hold, input logic br, input logic z,
                          input logic j, input logic jr, input logic [31:0] rs);
    int t;
    t = 0;
    while (!bus.imem_req && t < 20) begin
      @(negedge clk);
      t++;
    end
    check32("req_rise", 32'(bus.imem_req), 32'd1);
    check32("fetch_addr", bus.imem_addr, addr_lit);
    for (int i = 0; i < lat; i++) begin
      bus.instr_ready = 1'b1;
      bus.Jr          = 1'b1;
      bus.rs_data     = $urandom;
      @(negedge clk);
      check32("req_held", 32'(bus.imem_req), 32'd1);
    end
    clear_redirect();
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = rdata;
    @(posedge clk);
    mdl_instr = rdata;
    @(negedge clk);
    check32("valid_lat", 32'(bus.instr_valid), 32'd1);
    for (int i = 0; i < hold; i++) begin
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = $urandom;
      @(negedge clk);
    end
    bus.imem_ack    = 1'b0;
    bus.instr_ready = 1'b1;
    bus.Branch      = br;
    bus.Zero        = z;
    bus.Jump        = j;
    bus.Jr          = jr;
    bus.rs_data     = rs;
    @(posedge clk);
    mdl_pc = spec_next(mdl_pc, mdl_instr, br, z, j, jr, rs);
    @(negedge clk);
    clear_redirect();
  endtask

  initial begin
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
    clear_redirect();
    mdl_pc    = 32'h0;
    mdl_instr = 32'h0;
    mdl_err   = 1'b0;

    #12;
    check32("rst_req", 32'(bus.imem_req), 32'd0);
    check32("rst_valid", 32'(bus.instr_valid), 32'd0);
    check32("rst_instr", bus.instr, 32'h0);
    check32("rst_pc", bus.pc, 32'h0);
    check32("rst_pc_plus4", bus.pc_plus4, 32'h4);
    check32("rst_addr", bus.imem_addr, 32'h0);
    check32("rst_err", 32'(bus.fetch_err), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    //        addr           rdata          lat hold br    z     j     jr    rs
    do_fetch(32'h0000_0000, ADDI,           0,  0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    do_fetch(32'h0000_0004, ADDI,           0,  0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    do_fetch(32'h0000_0008, 32'h0800_0010,  0,  0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    do_fetch(32'h0000_0040, 32'h1000_FFFE,  0,  0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    do_fetch(32'h0000_003C, 32'h0800_0010,  0,  0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    do_fetch(32'h0000_0040, 32'h1000_FFFE,  0,  0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    do_fetch(32'h0000_0044, 32'h03E0_0008,  0,  0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1000_0010);
    do_fetch(32'h1000_0010, 32'h0800_0100,  0,  0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    do_fetch(32'h1000_0400, 32'h0800_0100,  0,  0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0203);
    do_fetch(32'h0000_0200, ADDI,           3,  5, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    do_fetch(32'h0000_0204, 32'h03E0_0008,  1,  0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    do_fetch(32'hFFFF_FFFC, ADDI,           2,  1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    do_fetch(32'h0000_0000, 32'h1400_0003,  1,  0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    do_fetch(32'h0000_0010, 32'h1000_0005,  0,  0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);

    // Reset asserted mid-WAIT with a stale ack arriving during reset.
    check32("pre_rst_addr", bus.imem_addr, 32'h0000_0014);
    @(negedge clk);
    @(posedge clk);
    #2;
    cmp_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check32("rst_mid_req", 32'(bus.imem_req), 32'd0);
    check32("rst_mid_pc", bus.pc, 32'h0);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    @(negedge clk);
    rst_n        = 1'b1;
    bus.imem_ack = 1'b0;
    mdl_pc       = 32'h0;
    mdl_instr    = 32'h0;
    @(negedge clk);
    check32("stale_instr", bus.instr, 32'h0);
    check32("stale_valid", 32'(bus.instr_valid), 32'd0);
    cmp_en = 1'b1;
    do_fetch(32'h0000_0000, ADDI, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

`ifdef FETCH_TIMEOUT_EN
    check32("to_req0", 32'(bus.imem_req), 32'd1);
    for (int i = 0; i < TO_CYCLES; i++) begin
      @(negedge clk);
      check32("to_req", 32'(bus.imem_req), 32'd1);
    end
    @(posedge clk);
    mdl_instr = 32'h0;
    mdl_err   = 1'b1;
    @(negedge clk);
    check32("to_valid", 32'(bus.instr_valid), 32'd1);
    check32("to_instr", bus.instr, 32'h0);
    check32("to_err", 32'(bus.fetch_err), 32'd1);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    bus.imem_ack    = 1'b0;
    bus.instr_ready = 1'b1;
    @(posedge clk);
    mdl_pc = spec_next(mdl_pc, mdl_instr, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    clear_redirect();
    do_fetch(32'h0000_0008, ADDI, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check32("err_sticky", 32'(bus.fetch_err), 32'd1);
`else
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check32("long_wait_req", 32'(bus.imem_req), 32'd1);
      check32("long_wait_valid", 32'(bus.instr_valid), 32'd0);
    end
    do_fetch(32'h0000_0004, ADDI, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check32("no_err", 32'(bus.fetch_err), 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end
endmodule
